// File: rtl/present_round_decrypt.sv
// rtl/present_round_decrypt.sv - round-based PRESENT-80 decryption core, one inverse round per cycle
//
// Ports:
//   clk          rising-edge clock
//   n_reset      asynchronous active-low reset
//   start        request, accepted only in IDLE or DONE
//   ciphertext   64-bit block, captured on the accept edge
//   key          80-bit key, captured on the accept edge
//   plaintext    registered result, valid while done=1
//   busy         high during key expansion and decryption
//   done         high while the result is held
//   round_count  current value of the shared round counter

module present_round_decrypt (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [63:0] ciphertext,
  input  logic [79:0] key,
  output logic [63:0] plaintext,
  output logic        busy,
  output logic        done,
  output logic [4:0]  round_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_DEC    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [63:0] pt_q, pt_d;
  logic [79:0] kreg_q, kreg_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [79:0] kreg_fwd;
  logic [79:0] kreg_inv;
  logic [63:0] round_out;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // Inverse bit permutation: output bit j is fetched from input bit 16*j mod 63,
  // which undoes the forward layer's move of bit i to 16*i mod 63.
  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] y;
    y[63] = x[63];
    for (int j = 0; j < 63; j++) begin
      y[j] = x[(16 * j) % 63];
    end
    return y;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Forward schedule step, same as the encryptor: rotate left by 61,
  // S-box on the top nibble, fold the round counter into bits 19:15.
  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_upd for the same counter value.
  function automatic logic [79:0] key_iupd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = sbox_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  assign kreg_fwd  = key_upd(kreg_q, cnt_q);
  assign kreg_inv  = key_iupd(kreg_q, cnt_q);
  assign round_out = inv_sbox_layer(inv_player(data_q ^ kreg_q[79:16]));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      data_q  <= 64'd0;
      kreg_q  <= 80'd0;
      cnt_q   <= 5'd0;
      pt_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // plaintext keeps the previous result across a restart; done gates its validity
        if (start) begin
          data_d  = ciphertext;
          kreg_d  = key;
          cnt_d   = 5'd1;
          state_d = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        kreg_d = kreg_fwd;
        if (cnt_q == 5'd31) begin
          // counter stays at 31 so the first inverse step undoes round 31
          state_d = ST_DEC;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DEC: begin
        data_d = round_out;
        kreg_d = kreg_inv;
        if (cnt_q == 5'd1) begin
          // kreg_inv is the original key here; its top 64 bits are the final whitening key
          pt_d    = round_out ^ kreg_inv[79:16];
          cnt_d   = 5'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  assign plaintext   = pt_q;
  assign busy        = (state_q == ST_KEYEXP) || (state_q == ST_DEC);
  assign done        = (state_q == ST_DONE);
  assign round_count = cnt_q;

endmodule
